// File: rtl/cache_mem_ctrl.sv
// Cache-side DRAM initiator: optional dirty-victim writeback followed by a line refill.
// All outputs are registered; one miss transaction is in flight at a time.
module cache_mem_ctrl #(
    parameter int AWIDTH     = 23,
    parameter int DWIDTH     = 128,
    parameter int CMD_CYCLES = 3,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wb,
    input  logic [AWIDTH-1:0] req_wb_addr,
    input  logic [DWIDTH-1:0] req_wb_data,
    input  logic [AWIDTH-1:0] req_fill_addr,
    output logic              resp_valid,
    output logic [DWIDTH-1:0] resp_data,
    output logic              resp_err,
    output logic              mem_wren,
    output logic              mem_rden,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_data_in,
    input  logic [DWIDTH-1:0] mem_data_out,
    input  logic              mem_ready
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        WB_CMD,
        WB_WAIT,
        RD_CMD,
        RD_WAIT,
        RESP
    } state_t;

    state_t            state, state_d;
    logic [CW-1:0]     cmd_cnt, cmd_cnt_d;
    logic [CW-1:0]     wait_cnt, wait_cnt_d;
    logic              err, err_d;
    logic [AWIDTH-1:0] wb_addr_q, wb_addr_d;
    logic [DWIDTH-1:0] wb_data_q, wb_data_d;
    logic [AWIDTH-1:0] fill_addr_q, fill_addr_d;
    logic              req_ready_d, resp_valid_d, resp_err_d;
    logic              mem_wren_d, mem_rden_d;
    logic [DWIDTH-1:0] resp_data_d, mem_data_in_d;
    logic [AWIDTH-1:0] mem_addr_d;

    logic cmd_last, wait_expired;
    assign cmd_last     = (cmd_cnt == CW'(CMD_CYCLES - 1));
    assign wait_expired = (wait_cnt == CW'(TIMEOUT));

    always_comb begin
        state_d       = state;
        cmd_cnt_d     = cmd_cnt;
        wait_cnt_d    = wait_cnt;
        err_d         = err;
        wb_addr_d     = wb_addr_q;
        wb_data_d     = wb_data_q;
        fill_addr_d   = fill_addr_q;
        req_ready_d   = req_ready;
        resp_valid_d  = 1'b0;
        resp_err_d    = 1'b0;
        resp_data_d   = resp_data;
        mem_wren_d    = mem_wren;
        mem_rden_d    = mem_rden;
        mem_addr_d    = mem_addr;
        mem_data_in_d = mem_data_in;

        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    wb_addr_d   = req_wb_addr;
                    wb_data_d   = req_wb_data;
                    fill_addr_d = req_fill_addr;
                    req_ready_d = 1'b0;
                    cmd_cnt_d   = '0;
                    wait_cnt_d  = '0;
                    err_d       = 1'b0;
                    resp_data_d = '0;
                    // The first command cycle is registered here so the memory sees it on the next edge.
                    if (req_wb) begin
                        state_d       = WB_CMD;
                        mem_wren_d    = 1'b1;
                        mem_addr_d    = req_wb_addr;
                        mem_data_in_d = req_wb_data;
                    end else begin
                        state_d    = RD_CMD;
                        mem_rden_d = 1'b1;
                        mem_addr_d = req_fill_addr;
                    end
                end
            end
            WB_CMD: begin
                if (cmd_last) begin
                    mem_wren_d = 1'b0;
                    cmd_cnt_d  = '0;
                    wait_cnt_d = '0;
                    state_d    = WB_WAIT;
                end else begin
                    cmd_cnt_d = cmd_cnt + 1'b1;
                end
            end
            WB_WAIT: begin
                if (mem_ready || wait_expired) begin
                    if (!mem_ready) err_d = 1'b1;
                    wait_cnt_d = '0;
                    cmd_cnt_d  = '0;
                    mem_rden_d = 1'b1;
                    mem_addr_d = fill_addr_q;
                    state_d    = RD_CMD;
                end else begin
                    wait_cnt_d = wait_cnt + 1'b1;
                end
            end
            RD_CMD: begin
                if (cmd_last) begin
                    mem_rden_d = 1'b0;
                    cmd_cnt_d  = '0;
                    wait_cnt_d = '0;
                    state_d    = RD_WAIT;
                end else begin
                    cmd_cnt_d = cmd_cnt + 1'b1;
                end
            end
            RD_WAIT: begin
                if (mem_ready) begin
                    resp_data_d  = mem_data_out;
                    resp_valid_d = 1'b1;
                    resp_err_d   = err;
                    wait_cnt_d   = '0;
                    state_d      = RESP;
                end else if (wait_expired) begin
                    err_d        = 1'b1;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    wait_cnt_d   = '0;
                    state_d      = RESP;
                end else begin
                    wait_cnt_d = wait_cnt + 1'b1;
                end
            end
            RESP: begin
                req_ready_d = 1'b1;
                err_d       = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                req_ready_d = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cmd_cnt     <= '0;
            wait_cnt    <= '0;
            err         <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            fill_addr_q <= '0;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            resp_data   <= '0;
            mem_wren    <= 1'b0;
            mem_rden    <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
        end else begin
            state       <= state_d;
            cmd_cnt     <= cmd_cnt_d;
            wait_cnt    <= wait_cnt_d;
            err         <= err_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            fill_addr_q <= fill_addr_d;
            req_ready   <= req_ready_d;
            resp_valid  <= resp_valid_d;
            resp_err    <= resp_err_d;
            resp_data   <= resp_data_d;
            mem_wren    <= mem_wren_d;
            mem_rden    <= mem_rden_d;
            mem_addr    <= mem_addr_d;
            mem_data_in <= mem_data_in_d;
        end
    end

endmodule

// File: doc/cache_mem_ctrl.md
Name: cache_mem_ctrl

Overview:
Cache-side initiator for the block-wide DRAM interface. Accepts one miss request per transaction from the cache controller FSM, optionally writes back a dirty victim line, then refills the requested line. Drives the memory's wren/rden/addr/data_in and waits for its mem_ready pulse. Sits between the data cache controller and the DRAM model / main memory port.

Parameters:
AWIDTH, 23, block (line) address width; byte address is {addr,4'b0000}
DWIDTH, 128, cache line width in bits (16 bytes)
CMD_CYCLES, 3, cycles wren/rden are held high per command (memory latency counter reaches 3)
TIMEOUT, 64, max cycles waiting for mem_ready after command release before error

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous reset, active-high
req_valid  in  1  miss request from cache FSM
req_ready  out  1  controller idle, request accepted when req_valid&&req_ready
req_wb  in  1  victim is dirty, perform writeback first
req_wb_addr  in  AWIDTH  victim line address
req_wb_data  in  DWIDTH  victim line data
req_fill_addr  in  AWIDTH  line address to refill
resp_valid  out  1  one-cycle pulse, refill complete
resp_data  out  DWIDTH  refilled line, valid with resp_valid
resp_err  out  1  one-cycle pulse with resp_valid when a timeout occurred
mem_wren  out  1  memory write enable
mem_rden  out  1  memory read enable
mem_addr  out  AWIDTH  memory line address
mem_data_in  out  DWIDTH  write data to memory
mem_data_out  in  DWIDTH  read data from memory
mem_ready  in  1  memory completion pulse

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_data=0; mem_wren=0; mem_rden=0; mem_addr=0; mem_data_in=0; counters=0; latched request cleared. Reset mid-transaction aborts immediately, no response produced; enables drop at that edge.
- All outputs registered. mem_wren and mem_rden never high in the same cycle.
- States: IDLE, WB_CMD, WB_WAIT, RD_CMD, RD_WAIT, RESP.
- IDLE: req_ready=1. On handshake, latch all req_* fields, req_ready->0; next state WB_CMD if req_wb else RD_CMD.
- WB_CMD: mem_wren=1, mem_addr=latched wb addr, mem_data_in=latched wb data, held exactly CMD_CYCLES consecutive cycles (cmd_cnt 0..CMD_CYCLES-1), then mem_wren=0 -> WB_WAIT.
- WB_WAIT: wait_cnt increments each cycle; mem_ready=1 -> RD_CMD, wait_cnt=0. wait_cnt reaches TIMEOUT -> set sticky err flag, proceed to RD_CMD.
- RD_CMD: mem_rden=1, mem_addr=latched fill addr, held CMD_CYCLES cycles, then 0 -> RD_WAIT.
- RD_WAIT: on mem_ready=1 capture mem_data_out into resp_data -> RESP. Timeout -> set err, resp_data unchanged from previous value captured in this transaction (0 if none), -> RESP.
- RESP: resp_valid=1 for exactly one cycle, resp_err=err flag; next cycle IDLE, req_ready=1, err cleared.
- mem_ready outside WB_WAIT/RD_WAIT ignored. mem_ready in the same cycle as the last command cycle ignored (command still active).
- req_valid while req_ready=0 ignored; no queueing.
- Minimum latency, clean line: handshake at cycle 0, rden cycles 1..3, mem_ready earliest cycle 4, resp_valid cycle 5 (if mem_ready at cycle N, resp_valid at N+1).
- Addresses passed unmodified; no wrap/offset arithmetic in this block. Counters sized ceil(log2(TIMEOUT+1)) bits, saturate never observed due to transition.

Test Plan:
- Clean miss: req_wb=0, fill_addr=0x000010, memory returns 0x0123..CDEF -> rden high exactly 3 cycles with mem_addr=0x000010, wren never high, resp_valid one cycle with resp_data=that line, resp_err=0.
- Dirty miss: req_wb=1, wb_addr=0x000004, wb_data=0xAA..AA, fill_addr=0x000008 -> wren 3 cycles at 0x4 with data 0xAA..AA, then after mem_ready rden 3 cycles at 0x8; readback of 0x4 via second request returns 0xAA..AA.
- Back-to-back: req_valid held high across two requests -> second accepted only in cycle after first resp_valid (req_ready=1), two distinct resp_valid pulses.
- Timeout: memory never asserts mem_ready -> resp_valid with resp_err=1 exactly TIMEOUT cycles after rden drops plus 1; next request completes with resp_err=0.
- Reset mid-op: assert rst during WB_CMD cycle 2 -> next cycle mem_wren=0, req_ready=1, no resp_valid; subsequent clean request behaves as scenario 1.
- Spurious mem_ready in IDLE and during RD_CMD -> ignored, no early resp_valid.
